// File: rtl/hazard_controller_pkg.sv
// Shared types for the decode-side hazard controller.
// Register index, FSM state and the pipeline control bundle.
package hazard_controller_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN      = 1'b0,
    REDIRECT = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic flush_id;
    logic flush_ex;
    logic id_issue;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/hazard_controller_if.sv
// Decode/EX/completion signals seen by the hazard controller.
// master drives the pipeline view, slave is the controller.
interface hazard_controller_if #(
  parameter int REG_ID_W = 6,
  parameter int NUM_REGS = 32
);

  logic                id_valid;
  logic [REG_ID_W-1:0] id_rs1;
  logic [REG_ID_W-1:0] id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic [REG_ID_W-1:0] id_rd;
  logic                id_reg_write;
  logic                id_is_load;
  logic                id_is_muldiv;
  logic                id_is_jalr;
  logic                ex_reg_write;
  logic [REG_ID_W-1:0] ex_rd;
  logic                ex_branch_taken;
  logic                lsu_done;
  logic [REG_ID_W-1:0] lsu_rd;
  logic                md_done;
  logic [REG_ID_W-1:0] md_rd;
  logic                id_issue;
  logic                stall_if;
  logic                stall_id;
  logic                flush_id;
  logic                flush_ex;
  logic [NUM_REGS-1:0] pending_mask;
  logic [2:0]          load_cnt;
  logic                md_busy;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_reg_write,
    output id_is_load, id_is_muldiv,
    output id_is_jalr,
    output ex_reg_write, ex_rd,
    output ex_branch_taken,
    output lsu_done, lsu_rd,
    output md_done, md_rd,
    input  id_issue, stall_if, stall_id,
    input  flush_id, flush_ex,
    input  pending_mask, load_cnt, md_busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_reg_write,
    input  id_is_load, id_is_muldiv,
    input  id_is_jalr,
    input  ex_reg_write, ex_rd,
    input  ex_branch_taken,
    input  lsu_done, lsu_rd,
    input  md_done, md_rd,
    output id_issue, stall_if, stall_id,
    output flush_id, flush_ex,
    output pending_mask, load_cnt, md_busy
  );

endinterface

// File: rtl/hazard_controller_scoreboard.sv
// Per-register pending-write bits for long-latency ops.
// One set port, two clear ports, rs1/rs2/rd lookups.
module hazard_controller_scoreboard
  import hazard_controller_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_a_en,
  input  logic [REG_IDX_W-1:0] clr_a_idx,
  input  logic                 clr_b_en,
  input  logic [REG_IDX_W-1:0] clr_b_idx,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  output logic                 rs1_pend,
  output logic                 rs2_pend,
  output logic                 rd_pend,
  output logic [NUM_REGS-1:0]  mask
);

  logic [NUM_REGS-1:0] mask_n;

  // clears first, then the set so a same-index set wins
  always_comb begin
    mask_n = mask;
    if (clr_a_en) mask_n[clr_a_idx] = 1'b0;
    if (clr_b_en) mask_n[clr_b_idx] = 1'b0;
    if (set_en) mask_n[set_idx] = 1'b1;
    mask_n[REG_ZERO] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (reset) mask <= '0;
    else       mask <= mask_n;
  end

  assign rs1_pend = mask[rs1_idx];
  assign rs2_pend = mask[rs2_idx];
  assign rd_pend  = mask[rd_idx];

  a_clr_a_pending : assert property (
    @(posedge clk) disable iff (reset)
    (clr_a_en && clr_a_idx != REG_ZERO)
      |-> mask[clr_a_idx]
  ) else $error("load clears a non-pending register");

  a_clr_b_pending : assert property (
    @(posedge clk) disable iff (reset)
    (clr_b_en && clr_b_idx != REG_ZERO)
      |-> mask[clr_b_idx]
  ) else $error("muldiv clears a non-pending register");

endmodule

// File: rtl/hazard_controller.sv
// Decode-side issue/stall controller: hazards, load and
// mul/div occupancy, and the RUN/REDIRECT flush sequencer.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int REG_ID_W        = 6,
  parameter int NUM_REGS        = 32,
  parameter int MAX_LOADS       = 2,
  parameter int REDIRECT_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  hazard_controller_if.slave bus
);

  hazard_state_t       state, state_n;
  logic [1:0]          rcnt, rcnt_n;
  logic [2:0]          load_cnt;
  logic                md_busy;
  logic [NUM_REGS-1:0] mask;
  hazard_ctrl_t        ctrl;

  logic [REG_IDX_W-1:0] rs1, rs2, rd;
  logic [REG_IDX_W-1:0] ex_rd, lsu_rd, md_rd;
  logic rs1_pend, rs2_pend, rd_pend;
  logic raw, waw, jalr_haz, struct_haz, hazard;
  logic issue, ld_inc, ld_dec, sb_set;
  logic unused_hi;

  assign rs1    = bus.id_rs1[REG_IDX_W-1:0];
  assign rs2    = bus.id_rs2[REG_IDX_W-1:0];
  assign rd     = bus.id_rd[REG_IDX_W-1:0];
  assign ex_rd  = bus.ex_rd[REG_IDX_W-1:0];
  assign lsu_rd = bus.lsu_rd[REG_IDX_W-1:0];
  assign md_rd  = bus.md_rd[REG_IDX_W-1:0];

  assign unused_hi = ^{
    bus.id_rs1[REG_ID_W-1:REG_IDX_W],
    bus.id_rs2[REG_ID_W-1:REG_IDX_W],
    bus.id_rd[REG_ID_W-1:REG_IDX_W],
    bus.ex_rd[REG_ID_W-1:REG_IDX_W],
    bus.lsu_rd[REG_ID_W-1:REG_IDX_W],
    bus.md_rd[REG_ID_W-1:REG_IDX_W]
  };

  assign issue  = ctrl.id_issue;
  assign sb_set = issue & bus.id_reg_write
                & (rd != REG_ZERO)
                & (bus.id_is_load | bus.id_is_muldiv);

  hazard_controller_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (sb_set),
    .set_idx   (rd),
    .clr_a_en  (bus.lsu_done),
    .clr_a_idx (lsu_rd),
    .clr_b_en  (bus.md_done),
    .clr_b_idx (md_rd),
    .rs1_idx   (rs1),
    .rs2_idx   (rs2),
    .rd_idx    (rd),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rd_pend   (rd_pend),
    .mask      (mask)
  );

  // hazard terms from registered state only
  always_comb begin
    raw = (bus.id_rs1_used & rs1_pend)
        | (bus.id_rs2_used & rs2_pend);
    waw = bus.id_reg_write & rd_pend;
    jalr_haz = bus.id_is_jalr & bus.ex_reg_write
             & (ex_rd == rs1) & (rs1 != REG_ZERO);
    struct_haz = (bus.id_is_muldiv & md_busy)
               | (bus.id_is_load
                  & (load_cnt == 3'(MAX_LOADS)));
    hazard = raw | waw | jalr_haz | struct_haz;
  end

  // next state and pipeline controls, silent in reset
  always_comb begin
    ctrl    = CTRL_NONE;
    state_n = state;
    rcnt_n  = rcnt;
    if (!reset) begin
      unique case (state)
        RUN: begin
          if (bus.ex_branch_taken) begin
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
            rcnt_n  = 2'(REDIRECT_CYCLES);
            state_n = REDIRECT;
          end else if (bus.id_valid && hazard) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
          end else if (bus.id_valid) begin
            ctrl.id_issue = 1'b1;
            if (bus.id_is_jalr) begin
              rcnt_n  = 2'(REDIRECT_CYCLES);
              state_n = REDIRECT;
            end
          end
        end
        REDIRECT: begin
          ctrl.flush_id = 1'b1;
          if (bus.ex_branch_taken) begin
            ctrl.flush_ex = 1'b1;
            rcnt_n = 2'(REDIRECT_CYCLES);
          end else if (rcnt == 2'd1) begin
            rcnt_n  = 2'd0;
            state_n = RUN;
          end else begin
            rcnt_n = rcnt - 2'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign ld_inc = issue & bus.id_is_load;
  assign ld_dec = bus.lsu_done;

  // FSM, redirect counter, load and mul/div occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      rcnt     <= 2'd0;
      load_cnt <= 3'd0;
      md_busy  <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      if (ld_inc && !ld_dec && load_cnt != 3'd7)
        load_cnt <= load_cnt + 3'd1;
      else if (ld_dec && !ld_inc && load_cnt != 3'd0)
        load_cnt <= load_cnt - 3'd1;
      if (issue && bus.id_is_muldiv)
        md_busy <= 1'b1;
      else if (bus.md_done)
        md_busy <= 1'b0;
    end
  end

  assign bus.id_issue     = ctrl.id_issue;
  assign bus.stall_if     = ctrl.stall_if;
  assign bus.stall_id     = ctrl.stall_id;
  assign bus.flush_id     = ctrl.flush_id;
  assign bus.flush_ex     = ctrl.flush_ex;
  assign bus.pending_mask = reset ? '0 : mask;
  assign bus.load_cnt     = reset ? 3'd0 : load_cnt;
  assign bus.md_busy      = reset ? 1'b0 : md_busy;

  a_done_same_rd : assert property (
    @(posedge clk) disable iff (reset)
    !(bus.lsu_done && bus.md_done
      && lsu_rd == md_rd && lsu_rd != REG_ZERO)
  ) else $error("lsu and muldiv complete to same rd");

  a_lsu_underflow : assert property (
    @(posedge clk) disable iff (reset)
    !(bus.lsu_done && load_cnt == 3'd0)
  ) else $error("lsu_done with no outstanding load");

  a_md_idle_done : assert property (
    @(posedge clk) disable iff (reset)
    !(bus.md_done && !md_busy)
  ) else $error("md_done while mul/div idle");

endmodule
